icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Sequences I$ line refills: accepts one miss from the I$ miss path, issues one AXI4 read burst, assembles beats into a full line, presents the line for a single-cycle fill into the I$ data/tag RAMs.
- Sits between the I$ and the shared AXI read channel.
- Honours fetch-pipeline flushes without violating AXI by draining outstanding beats and discarding the line.

Parameters:
- LINE_WIDTH, 256, I$ line width in bits; must be a multiple of BUS_WIDTH.
- BUS_WIDTH, 32, AXI read data width in bits.
- ID, 0, constant AXI arid driven on every request.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  fetch-pipeline flush (flush_pc or mispredict redirect); abandons the current refill.
- miss_valid  in  1  I$ requests a refill.
- miss_paddr  in  32  physical miss address.
- miss_ready  out  1  controller idle; the miss is accepted when miss_valid & miss_ready & ~flush.
- axi_arid  out  4  constant ID.
- axi_araddr  out  32  burst start address.
- axi_arlen  out  8  BEATS-1.
- axi_arsize  out  3  log2(BUS_WIDTH/8).
- axi_arburst  out  2  burst type.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address ready.
- axi_rdata  in  BUS_WIDTH  beat data.
- axi_rresp  in  2  beat response.
- axi_rlast  in  1  last beat.
- axi_rvalid  in  1  beat valid.
- axi_rready  out  1  beat ready.
- fill_valid  out  1  one-cycle pulse: the line is complete.
- fill_paddr  out  32  line-aligned address of the filled line.
- fill_data  out  LINE_WIDTH  line; word i holds bits [32i+31:32i].
- fill_err  out  1  any beat of the line returned rresp != OKAY; qualified by fill_valid.

Behaviour:
- BEATS = LINE_WIDTH/BUS_WIDTH; OFS = log2(LINE_WIDTH/8).
- FSM states: IDLE, ADDR, DATA, DRAIN, FILL.
- Reset (rst=0 at a posedge) forces IDLE from any state, including mid-burst, and clears the beat counter, the error flag and the line buffer.
- Reset output values: miss_ready=1, axi_arvalid=0, axi_rready=0, fill_valid=0, fill_err=0, fill_data=0, fill_paddr=0.
- Integration requirement: the AXI interconnect is reset together with this block, because reset does not drain an in-flight burst.
- IDLE:
  - miss_ready=1.
  - On acceptance, latch miss_paddr, clear the error flag and beat counter, go to ADDR.
  - flush in IDLE has no effect, except that it blocks acceptance in the same cycle.
- ADDR:
  - axi_arvalid=1, with address and burst type per the optional feature.
  - The address is held stable until axi_arready.
  - On the handshake: go to DATA, or to DRAIN if flush was seen in ADDR (the abort flag is sticky).
  - arvalid is never dropped before the handshake, even when flushed.
- DATA:
  - axi_rready=1.
  - Each accepted beat is written to word slot (start_word + cnt) mod BEATS; cnt increments and wraps at BEATS.
  - The error flag ORs in (rresp != 0).
  - On an accepted beat with rlast, go to FILL.
  - flush goes to DRAIN; a beat accepted in the same cycle as the flush is still counted and discarded.
- DRAIN:
  - axi_rready=1; beats are discarded.
  - On an accepted rlast, go to IDLE with no fill pulse.
  - If the abandoning flush coincided with the rlast beat, go directly to IDLE.
- FILL:
  - fill_valid=1 for exactly one cycle, with fill_paddr = {paddr[31:OFS], 0}, and fill_err set from the error flag.
  - If flush is high in this cycle, fill_valid is forced to 0.
  - Always returns to IDLE; the I$ must accept the fill in that cycle, so there is no backpressure.
- Latency with arready and rvalid always high: miss accepted at cycle T, arvalid at T+1, beats at T+2 through T+1+BEATS, fill_valid at T+2+BEATS, miss_ready at T+3+BEATS.
- The beat counter is the only mechanism for slot placement; termination is by rlast. In simulation, assert that rlast coincides with cnt == BEATS-1.
- Only one outstanding burst; miss_ready=0 in every state except IDLE.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - axi_arburst = WRAP (2'b10).
  - axi_araddr = {paddr[31:2], 2'b00}, i.e. the critical word first.
  - start_word = paddr[OFS-1:2].
  - Slot placement rotates so that fill_data is still in natural line order.
- Undefined:
  - axi_arburst = INCR (2'b01).
  - axi_araddr = {paddr[31:OFS], 0}.
  - start_word = 0.
- Both builds produce identical fill_data for the same memory contents.

Test Plan:
- Basic miss: miss_paddr=0x1FC0_0024, memory word k = 0xA000_0000+k, arready and rvalid always high -> one AR with arlen=7 at T+1; fill_paddr=0x1FC0_0020; fill_data word i = 0xA000_0008+i; fill_valid at T+10 for exactly 1 cycle.
- AR backpressure plus flush: arready low for 5 cycles, flush pulsed at cycle 2 of ADDR -> arvalid and araddr stay stable until the handshake; all 8 beats accepted; no fill_valid; miss_ready=1 after rlast.
- Flush mid-burst: flush on beat 3 of 8, rvalid toggled every other cycle -> remaining beats drained; fill_valid stays 0; a new miss accepted the cycle after returning to IDLE fills correctly.
- Error response: beat 5 has rresp=2'b10 -> fill_valid=1 with fill_err=1; the next clean refill has fill_err=0.
- Reset mid-burst: rst=0 on beat 4 -> the next cycle has miss_ready=1 and axi_rready=0, and all outputs are at their reset values.
- With ICACHE_CRITICAL_WORD_FIRST_EN: miss_paddr=0x8000_001C -> araddr=0x8000_001C, arburst=2; memory returns words 7,0,1,…,6; fill_data is in natural order and equals the INCR build's output.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Purpose: services one I$ miss at a time. It issues a single AXI4 read burst
// for the missing line, collects the beats into a line buffer and presents
// the finished line for a one-cycle fill into the I$ tag/data RAMs. A fetch
// pipeline flush abandons the refill. Beats that are still outstanding are
// drained so that the AXI protocol is never violated, and the line is dropped.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   flush             abandon the current refill
//   miss_valid/ready  miss request from the I$, plus the physical miss address
//   axi_ar*           AXI4 read address channel (master side)
//   axi_r*            AXI4 read data channel (master side)
//   fill_valid        one-cycle pulse carrying fill_paddr, fill_data, fill_err
//
// Build option: ICACHE_CRITICAL_WORD_FIRST_EN.
//   Defined:   a WRAP burst starts at the missed word. Beats are rotated into
//              their natural slots.
//   Undefined: an INCR burst starts at the line base.
//   Both builds present fill_data in natural line order.
//
// Reset does not drain an in-flight burst. The AXI interconnect must be reset
// together with this block.
//
// state | meaning
// IDLE  | waiting for a miss; miss_ready high
// ADDR  | AR request outstanding; address held until arready
// DATA  | collecting beats into the line buffer
// DRAIN | refill abandoned; accepting and discarding beats until rlast
// FILL  | line complete; fill_valid pulse
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 32,
    parameter int ID         = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  miss_valid,
    input  logic [31:0]           miss_paddr,
    output logic                  miss_ready,
    output logic [3:0]            axi_arid,
    output logic [31:0]           axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [BUS_WIDTH-1:0]  axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic                  fill_valid,
    output logic [31:0]           fill_paddr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  fill_err
);

    localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int OFS   = $clog2(LINE_WIDTH / 8);
    localparam int SZ    = $clog2(BUS_WIDTH / 8);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, FILL} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    abort_q, abort_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic [31:0]             fill_paddr_q, fill_paddr_d;
    logic                    fill_err_q, fill_err_d;
    logic                    miss_ready_q, arvalid_q, rready_q, fill_valid_q;

    logic                    beat_acc;
    logic [CW-1:0]           cnt_inc;
    logic [CW-1:0]           start_w;
    logic [CW:0]             slot_sum;
    logic [CW-1:0]           slot_idx;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign axi_arburst = 2'b10;
    assign axi_araddr  = {paddr_q[31:SZ], {SZ{1'b0}}};
    assign start_w     = paddr_q[OFS-1:SZ];
    wire   unused_paddr = ^paddr_q[SZ-1:0];
`else
    assign axi_arburst = 2'b01;
    assign axi_araddr  = {paddr_q[31:OFS], {OFS{1'b0}}};
    assign start_w     = '0;
    wire   unused_paddr = ^paddr_q[OFS-1:0];
`endif

    assign axi_arid   = 4'(ID);
    assign axi_arlen  = 8'(BEATS - 1);
    assign axi_arsize = 3'(SZ);

    assign miss_ready  = miss_ready_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    // A flush in the FILL cycle suppresses the fill.
    assign fill_valid  = fill_valid_q & ~flush;
    assign fill_paddr  = fill_paddr_q;
    assign fill_data   = line_q;
    assign fill_err    = fill_err_q;

    assign beat_acc = rready_q & axi_rvalid;
    assign cnt_inc  = (cnt_q == CW'(BEATS - 1)) ? '0 : cnt_q + 1'b1;

    // The first beat of a wrapped burst belongs in the slot of the missed word.
    assign slot_sum = {1'b0, start_w} + {1'b0, cnt_q};
    assign slot_idx = (slot_sum >= (CW+1)'(BEATS)) ? CW'(slot_sum - (CW+1)'(BEATS))
                                                   : slot_sum[CW-1:0];

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        abort_d      = abort_q;
        line_d       = line_q;
        fill_paddr_d = fill_paddr_q;
        fill_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_valid && miss_ready_q && !flush) begin
                    paddr_d = miss_paddr;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // arvalid stays up through a flush. The flush is remembered,
                // and the burst is drained once the address is accepted.
                if (flush) abort_d = 1'b1;
                if (arvalid_q && axi_arready)
                    state_d = (abort_q || flush) ? DRAIN : DATA;
            end
            DATA: begin
                if (beat_acc) begin
                    cnt_d = cnt_inc;
                    if (!flush) begin
                        line_d[slot_idx*BUS_WIDTH +: BUS_WIDTH] = axi_rdata;
                        err_d = err_q | (axi_rresp != 2'b00);
                    end
                end
                if (flush) begin
                    state_d = (beat_acc && axi_rlast) ? IDLE : DRAIN;
                end else if (beat_acc && axi_rlast) begin
                    state_d      = FILL;
                    fill_paddr_d = {paddr_q[31:OFS], {OFS{1'b0}}};
                    fill_err_d   = err_d;
                end
            end
            DRAIN: begin
                if (beat_acc) begin
                    cnt_d = cnt_inc;
                    if (axi_rlast) state_d = IDLE;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            abort_q      <= 1'b0;
            line_q       <= '0;
            fill_paddr_q <= '0;
            fill_err_q   <= 1'b0;
            miss_ready_q <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            fill_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
            line_q       <= line_d;
            fill_paddr_q <= fill_paddr_d;
            fill_err_q   <= fill_err_d;
            miss_ready_q <= (state_d == IDLE);
            arvalid_q    <= (state_d == ADDR);
            rready_q     <= (state_d == DATA) || (state_d == DRAIN);
            fill_valid_q <= (state_d == FILL);
        end
    end

`ifndef SYNTHESIS
    // Beats are placed by the counter, and the burst ends on rlast. Both must agree.
    property p_rlast_at_end;
        @(posedge clk) disable iff (!rst)
            (rready_q && axi_rvalid) |-> (axi_rlast == (cnt_q == CW'(BEATS - 1)));
    endproperty
    a_rlast_at_end: assert property (p_rlast_at_end);
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
`timescale 1ns/1ps
module tb_icache_refill_ctrl;

    localparam int LW = 256;
    localparam int BW = 32;
    localparam int NB = LW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          miss_valid;
    logic [31:0]   miss_paddr;
    logic          miss_ready;
    logic [3:0]    axi_arid;
    logic [31:0]   axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [BW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic          fill_valid;
    logic [31:0]   fill_paddr;
    logic [LW-1:0] fill_data;
    logic          fill_err;

    icache_refill_ctrl #(.LINE_WIDTH(LW), .BUS_WIDTH(BW), .ID(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .miss_valid(miss_valid), .miss_paddr(miss_paddr), .miss_ready(miss_ready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .fill_valid(fill_valid), .fill_paddr(fill_paddr), .fill_data(fill_data),
        .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: word value = pattern + word address bits [15:2].
    logic [31:0] pat = 32'hA000_0000;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return pat + {18'b0, a[15:2]};
    endfunction

    function automatic logic [LW-1:0] exp_line(input logic [31:0] pa);
        logic [LW-1:0] l;
        for (int i = 0; i < NB; i++)
            l[i*32 +: 32] = mem_word({pa[31:5], 5'b0} + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bt, input int idx);
        logic [2:0] w;
        if (bt == 2'b10) begin
            w = a[4:2] + 3'(idx);
            return {a[31:5], w, 2'b00};
        end
        return a + 32'(idx * 4);
    endfunction

    typedef struct {
        logic [31:0]   paddr;
        logic [LW-1:0] data;
        logic          err;
    } exp_t;
    exp_t sb[$];

    // ---------------- AXI slave model (acts 2ns after negedge) --------------
    int          ar_stall  = 0;
    bit          rv_toggle = 0;
    int          err_beat  = -1;
    bit          b_act     = 0;
    logic [31:0] b_addr;
    logic [1:0]  b_burst;
    int          b_idx     = 0;
    int          beats_done = 0;
    int          ar_hs_cnt = 0;
    bit          tog       = 0;

    initial begin
        axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0; axi_rresp = 0;
        forever begin
            @(negedge clk); #2;
            if (!rst) begin
                b_act = 0; axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
            end else begin
                if (b_act && (!rv_toggle || tog)) begin
                    axi_rvalid = 1;
                    axi_rdata  = mem_word(beat_addr(b_addr, b_burst, b_idx));
                    axi_rlast  = (b_idx == NB - 1);
                    axi_rresp  = (b_idx == err_beat) ? 2'b10 : 2'b00;
                    if (axi_rready) begin
                        b_idx++;
                        beats_done++;
                        if (b_idx == NB) b_act = 0;
                    end
                end else begin
                    axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
                end
                tog = ~tog;
                if (axi_arvalid && !b_act) begin
                    if (ar_stall > 0) begin
                        axi_arready = 0;
                        ar_stall--;
                    end else begin
                        axi_arready = 1;
                        b_addr = axi_araddr; b_burst = axi_arburst;
                        b_idx = 0; b_act = 1; ar_hs_cnt++;
                    end
                end else begin
                    axi_arready = 0;
                end
            end
        end
    end

    // ---------------- fill monitor / scoreboard (3ns after negedge) ---------
    int fill_cnt = 0;
    int fill_cyc = -1;

    initial begin
        forever begin
            @(negedge clk); #3;
            if (rst && fill_valid) begin
                fill_cnt++;
                fill_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_fill", 256'(fill_valid), 256'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fill_paddr", 256'(fill_paddr), 256'(e.paddr));
                    chk("fill_data", fill_data, e.data);
                    chk("fill_err", 256'(fill_err), 256'(e.err));
                end
            end
        end
    end

    // ---------------- main stimulus (drives at negedge) ---------------------
    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while (!miss_ready && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk({tag, "_timeout"}, 256'(miss_ready), 256'(1));
    endtask

    task automatic wait_beats(input string tag, input int k, input int lim);
        int n = 0;
        while (beats_done < k && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk({tag, "_timeout"}, 256'(beats_done), 256'(k));
    endtask

    task automatic do_miss(input logic [31:0] pa, input bit exp_fill, input logic exp_err, output int t);
        wait_idle("pre_miss", 200);
        miss_valid = 1; miss_paddr = pa; beats_done = 0;
        t = cyc;
        if (exp_fill) sb.push_back('{paddr: {pa[31:5], 5'b0}, data: exp_line(pa), err: exp_err});
        @(negedge clk);
        miss_valid = 0;
    endtask

    int t, fc0, h0;
    logic [31:0] a0;

    initial begin
        rst = 0; flush = 0; miss_valid = 0; miss_paddr = '0;
        repeat (3) @(negedge clk);
        chk("rst_miss_ready", 256'(miss_ready), 256'(1));
        chk("rst_arvalid", 256'(axi_arvalid), 256'(0));
        chk("rst_rready", 256'(axi_rready), 256'(0));
        chk("rst_fill_valid", 256'(fill_valid), 256'(0));
        chk("rst_fill_err", 256'(fill_err), 256'(0));
        chk("rst_fill_data", fill_data, 256'(0));
        chk("rst_fill_paddr", 256'(fill_paddr), 256'(0));
        rst = 1;
        @(negedge clk);

        // Basic miss with full latency check.
        fc0 = fill_cnt;
        do_miss(32'h1FC0_0024, 1, 0, t);
        chk("t1_arvalid", 256'(axi_arvalid), 256'(1));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        chk("t1_araddr", 256'(axi_araddr), 256'(32'h1FC0_0024));
        chk("t1_arburst", 256'(axi_arburst), 256'(2));
`else
        chk("t1_araddr", 256'(axi_araddr), 256'(32'h1FC0_0020));
        chk("t1_arburst", 256'(axi_arburst), 256'(1));
`endif
        chk("t1_arlen", 256'(axi_arlen), 256'(7));
        chk("t1_arsize", 256'(axi_arsize), 256'(2));
        chk("t1_arid", 256'(axi_arid), 256'(0));
        chk("t1_miss_ready_busy", 256'(miss_ready), 256'(0));
        wait_idle("t1_done", 40);
        chk("t1_fill_cycle", 256'(fill_cyc), 256'(t + 10));
        chk("t1_idle_cycle", 256'(cyc), 256'(t + 11));
        chk("t1_fill_pulses", 256'(fill_cnt - fc0), 256'(1));

        // Flush in IDLE blocks acceptance.
        miss_valid = 1; miss_paddr = 32'h0000_0F00; flush = 1;
        @(negedge clk);
        miss_valid = 0; flush = 0;
        chk("idle_flush_ready", 256'(miss_ready), 256'(1));
        chk("idle_flush_arvalid", 256'(axi_arvalid), 256'(0));

        // AR backpressure with flush during ADDR.
        fc0 = fill_cnt; h0 = ar_hs_cnt; ar_stall = 5;
        do_miss(32'h0000_1040, 0, 0, t);
        a0 = axi_araddr;
        chk("t2_arvalid_first", 256'(axi_arvalid), 256'(1));
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid_hold", 256'(axi_arvalid), 256'(1));
            chk("t2_araddr_hold", 256'(axi_araddr), 256'(a0));
            @(negedge clk);
        end
        wait_idle("t2_drain", 40);
        chk("t2_idle_cycle", 256'(cyc), 256'(t + 15));
        chk("t2_beats", 256'(beats_done), 256'(8));
        chk("t2_ar_count", 256'(ar_hs_cnt - h0), 256'(1));
        chk("t2_no_fill", 256'(fill_cnt - fc0), 256'(0));

        // Flush mid-burst, rvalid every other cycle, then immediate new miss.
        fc0 = fill_cnt; rv_toggle = 1;
        do_miss(32'h0000_2000, 0, 0, t);
        wait_beats("t3_beat3", 3, 40);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_idle("t3_drain", 60);
        chk("t3_beats", 256'(beats_done), 256'(8));
        chk("t3_no_fill", 256'(fill_cnt - fc0), 256'(0));
        pat = 32'h5500_0000;
        do_miss(32'h0000_2104, 1, 0, t);
        wait_idle("t3_refill", 60);
        chk("t3_refill_pulses", 256'(fill_cnt - fc0), 256'(1));
        rv_toggle = 0;

        // Error response on beat 5, then a clean refill.
        pat = 32'hB000_0000; err_beat = 5;
        do_miss(32'h0000_3000, 1, 1, t);
        wait_idle("t4_err", 40);
        err_beat = -1;
        do_miss(32'h0000_3020, 1, 0, t);
        wait_idle("t4_clean", 40);
        chk("t4_sb_drained", 256'(sb.size()), 256'(0));

        // Flush coinciding with rlast goes straight to IDLE.
        fc0 = fill_cnt;
        do_miss(32'h0000_4000, 0, 0, t);
        repeat (8) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("t5_direct_idle", 256'(miss_ready), 256'(1));
        chk("t5_rready_off", 256'(axi_rready), 256'(0));
        chk("t5_no_fill", 256'(fill_cnt - fc0), 256'(0));

        // Flush in the FILL cycle suppresses fill_valid.
        fc0 = fill_cnt;
        do_miss(32'h0000_4040, 0, 0, t);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("t6_idle", 256'(miss_ready), 256'(1));
        chk("t6_no_fill", 256'(fill_cnt - fc0), 256'(0));

        // Reset mid-burst.
        do_miss(32'h0000_5000, 0, 0, t);
        wait_beats("t7_beat4", 4, 40);
        rst = 0;
        @(negedge clk);
        chk("t7_miss_ready", 256'(miss_ready), 256'(1));
        chk("t7_rready", 256'(axi_rready), 256'(0));
        chk("t7_arvalid", 256'(axi_arvalid), 256'(0));
        chk("t7_fill_valid", 256'(fill_valid), 256'(0));
        chk("t7_fill_err", 256'(fill_err), 256'(0));
        chk("t7_fill_data", fill_data, 256'(0));
        chk("t7_fill_paddr", 256'(fill_paddr), 256'(0));
        rst = 1;
        @(negedge clk);
        do_miss(32'h0000_5040, 1, 0, t);
        wait_idle("t7_recover", 40);

        // Critical word at the end of the line.
        pat = 32'hC000_0000;
        do_miss(32'h8000_001C, 1, 0, t);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        chk("t8_araddr", 256'(axi_araddr), 256'(32'h8000_001C));
        chk("t8_arburst", 256'(axi_arburst), 256'(2));
`else
        chk("t8_araddr", 256'(axi_araddr), 256'(32'h8000_0000));
        chk("t8_arburst", 256'(axi_arburst), 256'(1));
`endif
        wait_idle("t8_done", 40);

        repeat (2) @(negedge clk);
        chk("sb_empty", 256'(sb.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
